// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the buffered UART transmitter.
//   uart_state_t   : transmitter FSM state encoding (legacy-compatible constants)
//   PARITY_MODE_*  : values accepted by the PARITY_ODD parameter
//   cnt_w()        : width of a counter that must hold 0..n-1 (never less than 1)
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  localparam int PARITY_MODE_EVEN = 0;
  localparam int PARITY_MODE_ODD  = 1;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count.
//   clk, reset_n : clock and asynchronous active-low reset
//   push, din    : write request and data; ignored while full (no bypass)
//   pop, dout    : read request and head-of-queue data (valid while !empty)
//   full, empty  : derived from the registered count
//   count        : number of entries held, 0..DEPTH
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = cnt_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];
  assign count   = count_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count_q,
  // so stale contents are never observed and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter. Bytes pushed with send_enable are
// queued and sent LSB-first as start / data / [parity] / stop bits.
//   clk, reset_n          : clock and asynchronous active-low reset
//   send_enable, data_in  : push request and data (one entry per cycle)
//   ready                 : FIFO not full
//   tx                    : registered serial line, idle high
//   busy                  : a frame is in progress
//   fifo_count            : entries queued
//   overflow              : one-cycle pulse after a dropped push
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          send_enable,
  input  logic [DATA_W-1:0]             data_in,
  output logic                          ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int BAUD_W = cnt_w(CLKS_PER_BIT);
  localparam int BIT_W  = cnt_w(DATA_W);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              ODD_PAR   = (PARITY_ODD == PARITY_MODE_ODD);

  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;

  uart_state_t       state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift_reg;
  logic              parity_bit;
  logic              tx_q;
  logic              overflow_q;
  logic              baud_end;
  logic              frame_done;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (send_enable),
    .pop     (fifo_pop),
    .din     (data_in),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign baud_end   = (baud_cnt == BAUD_LAST);
  assign frame_done = (state == ST_STOP) && baud_end && (bit_idx == STOP_LAST);
  // Pop either from idle or on the final stop cycle, so queued bytes go out
  // back-to-back with no idle gap.
  assign fifo_pop   = ~fifo_empty & ((state == ST_IDLE) | frame_done);

  assign ready    = ~fifo_full;
  assign tx       = tx_q;
  assign busy     = (state != ST_IDLE);
  assign overflow = overflow_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overflow_q <= 1'b0;
    else          overflow_q <= send_enable & fifo_full;
  end

  // tx_q is loaded together with each state change, so the line level is a
  // register output that changes only at bit boundaries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx_q       <= 1'b1;
    end else if (fifo_pop) begin
      state      <= ST_START;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= fifo_dout;
      parity_bit <= (^fifo_dout) ^ ODD_PAR;
      tx_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_q <= 1'b1;
        end
        ST_START: begin
          if (baud_end) begin
            state    <= ST_DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                state <= ST_PARITY;
                tx_q  <= parity_bit;
              end else begin
                state <= ST_STOP;
                tx_q  <= 1'b1;
              end
            end else begin
              bit_idx   <= bit_idx + BIT_W'(1);
              shift_reg <= {1'b0, shift_reg[DATA_W-1:1]};
              tx_q      <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        ST_PARITY: begin
          if (baud_end) begin
            state    <= ST_STOP;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              state   <= ST_IDLE;
              bit_idx <= '0;
              tx_q    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          baud_cnt <= '0;
          bit_idx  <= '0;
          tx_q     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo.
// Four instances share clk/reset_n: defaults (8N1), even parity, odd parity,
// and 5 data bits with 2 stop bits; all run at 4 clocks per bit.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset_n;

  logic       se_a, se_pe, se_po, se_w5;
  logic [7:0] d_a, d_pe, d_po;
  logic [4:0] d_w5;
  logic       rdy_a, rdy_pe, rdy_po, rdy_w5;
  logic       tx_a, tx_pe, tx_po, tx_w5;
  logic       busy_a, busy_pe, busy_po, busy_w5;
  logic [3:0] cnt_a, cnt_pe, cnt_po, cnt_w5;
  logic       ovf_a, ovf_pe, ovf_po, ovf_w5;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB)) u_a (
    .clk(clk), .reset_n(reset_n), .send_enable(se_a), .data_in(d_a),
    .ready(rdy_a), .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a), .overflow(ovf_a));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u_pe (
    .clk(clk), .reset_n(reset_n), .send_enable(se_pe), .data_in(d_pe),
    .ready(rdy_pe), .tx(tx_pe), .busy(busy_pe), .fifo_count(cnt_pe), .overflow(ovf_pe));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) u_po (
    .clk(clk), .reset_n(reset_n), .send_enable(se_po), .data_in(d_po),
    .ready(rdy_po), .tx(tx_po), .busy(busy_po), .fifo_count(cnt_po), .overflow(ovf_po));

  uart_tx_fifo #(.DATA_W(5), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_w5 (
    .clk(clk), .reset_n(reset_n), .send_enable(se_w5), .data_in(d_w5),
    .ready(rdy_w5), .tx(tx_w5), .busy(busy_w5), .fifo_count(cnt_w5), .overflow(ovf_w5));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_tx(input int sel);
    case (sel)
      1:       return tx_pe;
      2:       return tx_po;
      3:       return tx_w5;
      default: return tx_a;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      1:       return busy_pe;
      2:       return busy_po;
      3:       return busy_w5;
      default: return busy_a;
    endcase
  endfunction

  // Frame-local cycles first..last: bits[i] is the i-th bit on the line, each
  // held CPB cycles; busy must stay high throughout. Entered at the sample for
  // cycle 'first', leaves at the sample for cycle last+1.
  task automatic check_tx(input int sel, input logic [31:0] bits,
                          input int first, input int last, input string tag);
    int   bad      = 0;
    int   bad_busy = 0;
    logic exp;
    for (int n = first; n <= last; n++) begin
      exp = bits[n / CPB];
      if (get_tx(sel) !== exp) bad++;
      if (get_busy(sel) !== 1'b1) bad_busy++;
      if ((n % CPB == CPB - 1) || (n == last)) begin
        check($sformatf("%s bit%0d bad_cycles", tag, n / CPB), bad, 0);
        bad = 0;
      end
      step();
    end
    check($sformatf("%s busy_low_cycles", tag), bad_busy, 0);
  endtask

  function automatic logic [31:0] frame8(input logic [7:0] b);
    return {22'd0, 1'b1, b, 1'b0};
  endfunction

  initial begin
    int idle_bad;
    se_a = 0; se_pe = 0; se_po = 0; se_w5 = 0;
    d_a = 0; d_pe = 0; d_po = 0; d_w5 = 0;
    reset_n = 1'b0;

    // Reset state
    #12;
    check("rst tx", tx_a, 1);
    check("rst busy", busy_a, 0);
    check("rst count", cnt_a, 0);
    check("rst ready", rdy_a, 1);
    check("rst overflow", ovf_a, 0);
    reset_n = 1'b1;
    step();

    // 0xA5, 8N1: tx falls one cycle after accept, 40-cycle frame
    se_a = 1; d_a = 8'hA5;
    step();
    se_a = 0;
    check("a5 count_after_push", cnt_a, 1);
    check("a5 tx_idle_at_accept", tx_a, 1);
    check("a5 busy_at_accept", busy_a, 0);
    step();
    check_tx(0, 32'b1_10100101_0, 0, 39, "a5");
    check("a5 busy_end", busy_a, 0);
    check("a5 tx_end", tx_a, 1);

    // Even parity, 0x07 -> parity 1, 44-cycle frame
    se_pe = 1; d_pe = 8'h07;
    step();
    se_pe = 0;
    step();
    check_tx(1, 32'b1_1_00000111_0, 0, 43, "par_even");
    check("par_even busy_end", busy_pe, 0);

    // Odd parity, 0x07 -> parity 0
    se_po = 1; d_po = 8'h07;
    step();
    se_po = 0;
    step();
    check_tx(2, 32'b1_0_00000111_0, 0, 43, "par_odd");
    check("par_odd busy_end", busy_po, 0);

    // DATA_W=5, 2 stop bits, 0x13 -> 0 | 1 1 0 0 1 | 1 1
    se_w5 = 1; d_w5 = 5'h13;
    step();
    se_w5 = 0;
    step();
    check_tx(3, 32'b11_10011_0, 0, 31, "w5");
    check("w5 busy_end", busy_w5, 0);

    // Three consecutive pushes -> three back-to-back frames (120 cycles)
    se_a = 1; d_a = 8'h11;
    step();
    check("b2b count0", cnt_a, 1);
    d_a = 8'h22;
    step();
    check("b2b count1", cnt_a, 1);
    check("b2b start0", tx_a, 0);
    d_a = 8'h33;
    step();
    se_a = 0;
    check("b2b count2", cnt_a, 2);
    check_tx(0, frame8(8'h11), 1, 39, "b2b f0");
    check("b2b count_after_pop2", cnt_a, 1);
    check_tx(0, frame8(8'h22), 0, 39, "b2b f1");
    check("b2b count_after_pop3", cnt_a, 0);
    check_tx(0, frame8(8'h33), 0, 39, "b2b f2");
    check("b2b busy_end", busy_a, 0);

    // Overflow: frame in flight, then 9 pushes into a depth-8 FIFO
    se_a = 1; d_a = 8'h40;
    step();
    se_a = 0;
    step();
    check("ovf start", tx_a, 0);
    se_a = 1;
    for (int k = 0; k < 9; k++) begin
      d_a = 8'h41 + 8'(k);
      step();
      if (k == 7) begin
        check("ovf count_full", cnt_a, 8);
        check("ovf ready_low", rdy_a, 0);
        check("ovf no_pulse_yet", ovf_a, 0);
      end
    end
    se_a = 0;
    check("ovf pulse", ovf_a, 1);
    check("ovf count_unchanged", cnt_a, 8);
    step();
    check("ovf pulse_one_cycle", ovf_a, 0);
    check_tx(0, frame8(8'h40), 10, 39, "ovf f40");
    check("ovf ready_after_pop", rdy_a, 1);
    check("ovf count_after_pop", cnt_a, 7);
    for (int k = 0; k < 8; k++) begin
      check_tx(0, frame8(8'h41 + 8'(k)), 0, 39, $sformatf("ovf f%0h", 8'h41 + k));
    end
    check("ovf busy_end", busy_a, 0);
    check("ovf count_end", cnt_a, 0);

    // Reset mid data bit with 4 bytes queued
    se_a = 1;
    for (int k = 0; k < 5; k++) begin
      d_a = 8'h50 + 8'(k);
      step();
    end
    se_a = 0;
    check("rstmid count", cnt_a, 4);
    step(); step(); step();
    check("rstmid in_data_bit0", tx_a, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid tx", tx_a, 1);
    check("rstmid busy", busy_a, 0);
    check("rstmid count", cnt_a, 0);
    check("rstmid ready", rdy_a, 1);
    check("rstmid overflow", ovf_a, 0);
    step(); step();
    reset_n = 1'b1;
    idle_bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || cnt_a !== 4'd0) idle_bad++;
    end
    check("rstmid idle_after_release", idle_bad, 0);
    se_a = 1; d_a = 8'h3C;
    step();
    se_a = 0;
    step();
    check_tx(0, 32'b1_00111100_0, 0, 39, "post_rst 3c");
    check("post_rst busy_end", busy_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter that replaces the simulation-only print path for accumulator output with a real serial line. Bytes written by the CPU's output instruction are queued in a small FIFO and shifted out LSB-first on `tx`. Data width, FIFO depth, baud divisor, parity and stop-bit count are configurable. Sits between the datapath (ACC, `send_enable`) and the board pin.

## Interface
- `DATA_W`, 8: data bits per frame, legal 5..9.
- `FIFO_DEPTH`, 8: queue entries, power of 2, ≥2.
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit, ≥2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity; ignored if `PARITY_EN`=0.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `send_enable`  in  1  push request; one entry per cycle high.
- `data_in`  in  DATA_W  data to queue, sampled with `send_enable`.
- `ready`  out  1  FIFO not full.
- `tx`  out  1  serial line, registered, idle high.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  entries queued.
- `overflow`  out  1  one-cycle pulse when a push is dropped.

## Operation
- Push accepted iff `send_enable`=1 and `ready`=1 at the edge. If `send_enable`=1 and `ready`=0: data dropped, `overflow`=1 the next cycle, FIFO unchanged. There is no same-cycle bypass: a full FIFO rejects even when a pop occurs that cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1. If FIFO non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: shift out DATA_W bits LSB-first, CLKS_PER_BIT cycles each. Then go to PARITY if `PARITY_EN`, else STOP.
  - PARITY: `tx` = XOR of the data bits, inverted when `PARITY_ODD`.
  - STOP: `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles. On the last cycle, if FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. Bit index counts 0..DATA_W-1 (and 0..STOP_BITS-1 in STOP). Both clear on every state change.
- Frame length = CLKS_PER_BIT×(1+DATA_W+PARITY_EN+STOP_BITS) cycles.
- Simultaneous push and pop: both take effect; `fifo_count` is unchanged.
- Reset (asynchronous, any time including mid-frame) forces:
  - `tx`=1, state IDLE, FIFO emptied;
  - `fifo_count`=0, `ready`=1, `busy`=0, `overflow`=0;
  - counters 0.
  - The partial frame is abandoned, not completed.

## Timing
- Push at edge E0 → `fifo_count` increments after E0 → IDLE pops at E1 → `tx` falls after E1. Latency is one cycle from accept to start bit when idle.
- `busy` rises with the start bit. It falls on the cycle after the final stop-bit cycle, only if the FIFO is empty.
- `ready` and `fifo_count` are registered and reflect state after the current edge.
- `overflow` is high for exactly one cycle per dropped push.
- Each `tx` level is stable for exactly CLKS_PER_BIT cycles; no glitches at bit boundaries.

## Structure
- Package `uart_pkg`: FSM state enum `uart_state_t`, parity-mode constants, and a function for counter width (`$clog2` wrapper).
- Sub-module `sync_fifo`: parametrised by width and depth, with push/pop/full/empty/count. The transmitter FSM, baud counter and shift register live in `uart_tx_fifo`.

## Test plan
- Defaults with CLKS_PER_BIT=4, push 0xA5 → `tx` carries:
  - start bit 0 for 4 cycles;
  - data bits 1,0,1,0,0,1,0,1, each 4 cycles;
  - stop bit 1 for 4 cycles.
  
  `busy` is high for 40 cycles; `tx` falls one cycle after the accept edge.
- PARITY_EN=1: even parity with 0x07 → parity bit 1; odd parity with 0x07 → parity bit 0; 44-cycle frame.
- Push 3 bytes on consecutive cycles → three frames back-to-back, 120 cycles total. There is no idle high between the stop bit and the next start bit. `fifo_count` reads 1,2,1,0 as bytes are popped.
- With a frame in progress, push 9 more bytes (DEPTH=8) → `ready` drops after the 8th. The 9th push produces a single `overflow` pulse and is dropped. All 8 queued bytes are later transmitted intact.
- Assert `reset_n`=0 mid-data-bit with 4 bytes queued → `tx`=1 immediately; `busy`=0, `fifo_count`=0. After release, `tx` stays idle; a new push 0x3C transmits correctly.
- DATA_W=5, STOP_BITS=2, push 0x13 → `tx` carries 0, then 1,1,0,0,1, then 1,1 (each CLKS_PER_BIT cycles); frame length 8×CLKS_PER_BIT.
